// File: rtl/vector_xbar_route_ctrl_if.sv
// Config/swap handshake bundle between a route programmer and vector_xbar_route_ctrl.
// The master side loads lane beats and requests swaps; the slave side owns the active mask.
interface vector_xbar_route_ctrl_if;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [7:0]   cfg_data;
  logic         cfg_abort;
  logic         swap_req;
  logic         swap_ack;
  logic         shadow_full;
  logic         cfg_err;
  logic [319:0] routing_bitmask;

  modport master (
    output cfg_valid, cfg_data, cfg_abort, swap_req,
    input  cfg_ready, swap_ack, shadow_full, cfg_err, routing_bitmask
  );

  modport slave (
    input  cfg_valid, cfg_data, cfg_abort, swap_req,
    output cfg_ready, swap_ack, shadow_full, cfg_err, routing_bitmask
  );
endinterface

// File: rtl/vector_xbar_route_ctrl.sv
// Double-buffered crossbar route table: 20 lane beats fill a shadow store, a swap publishes it
// as a one-hot-per-lane mask. Optional beat parity checking via VEC_XBAR_CFG_PARITY_EN.
module vector_xbar_route_ctrl (
  input  logic                    clk,
  input  logic                    rst_n,
  vector_xbar_route_ctrl_if.slave bus
);

  typedef enum logic {LOAD, FULL} state_t;

  localparam int LANES = 20;

  state_t         state, state_next;
  logic [4:0]     lane_cnt;
  logic [3:0]     shadow_idx [LANES];
  logic           shadow_en  [LANES];
  logic [319:0]   mask_q, mask_decoded;
  logic           swap_ack_q;
  logic           cfg_ready_int;
  logic           accept;
  logic           do_swap;
  logic           parity_ok;
  logic           cfg_err_int;

  assign cfg_ready_int       = rst_n && (state == LOAD);
  assign accept              = bus.cfg_valid && cfg_ready_int && !bus.cfg_abort;
  assign bus.cfg_ready       = cfg_ready_int;
  assign bus.swap_ack        = swap_ack_q;
  assign bus.shadow_full     = (state == FULL);
  assign bus.routing_bitmask = mask_q;
  assign bus.cfg_err         = cfg_err_int;

`ifdef VEC_XBAR_CFG_PARITY_EN
  logic unused_rsvd;
  assign unused_rsvd = ^bus.cfg_data[6:5];
  assign parity_ok   = ^bus.cfg_data;

  // A bad-parity beat still occupies its lane, but is stored disabled; the error is sticky.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_err_int <= 1'b0;
    end else if (accept && !parity_ok) begin
      cfg_err_int <= 1'b1;
    end
  end
`else
  logic unused_rsvd;
  assign unused_rsvd = ^bus.cfg_data[7:5];
  assign parity_ok   = 1'b1;
  assign cfg_err_int = 1'b0;
`endif

  always_comb begin
    mask_decoded = '0;
    for (int i = 0; i < LANES; i++) begin
      if (shadow_en[i]) begin
        mask_decoded[16*i +: 16] = 16'(1) << shadow_idx[i];
      end
    end
  end

  // Abort dominates both a beat and a swap presented in the same cycle.
  always_comb begin
    state_next = state;
    do_swap    = 1'b0;
    if (bus.cfg_abort) begin
      state_next = LOAD;
    end else begin
      unique case (state)
        LOAD: if (accept && lane_cnt == 5'd19) state_next = FULL;
        FULL: if (bus.swap_req) begin
          state_next = LOAD;
          do_swap    = 1'b1;
        end
        default: state_next = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= LOAD;
      lane_cnt   <= '0;
      mask_q     <= '0;
      swap_ack_q <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        shadow_idx[i] <= '0;
        shadow_en[i]  <= 1'b0;
      end
    end else begin
      state      <= state_next;
      swap_ack_q <= do_swap;
      if (bus.cfg_abort) begin
        lane_cnt <= '0;
      end else if (accept) begin
        shadow_idx[lane_cnt] <= bus.cfg_data[3:0];
        shadow_en[lane_cnt]  <= bus.cfg_data[4] && parity_ok;
        lane_cnt             <= (lane_cnt == 5'd19) ? 5'd0 : lane_cnt + 5'd1;
      end
      if (do_swap) begin
        mask_q <= mask_decoded;
      end
    end
  end

endmodule
